// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//
// Two-requester left-shift engine. In IDLE one requester is granted (round
// robin or fixed priority to requester 0), its operand is captured and shifted
// left one position per clock, using a single-position shifter, until the
// requested amount is reached. The result is then held in DONE until the
// consumer takes it.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid/data/amt/ready  requester N job handshake (N = 0, 1);
//                              ready is combinational and only high in IDLE
//   res_valid/data/id/ready    result handshake; res_id = owning requester
//   busy                       high whenever the FSM is not in IDLE
// Parameter:
//   RR_EN                      1 = round-robin grant, 0 = requester 0 wins
// -----------------------------------------------------------------------------

// Single-position left shifter: out = inp << 1 when s, else inp unchanged.
module shift1 (
    input  logic       s,
    input  logic [2:0] inp,
    output logic [2:0] out
);
    assign out = s ? {inp[1:0], 1'b0} : inp;
endmodule

module shift_sequencer #(
    parameter logic RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [2:0] req0_data,
    input  logic [1:0] req0_amt,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [2:0] req1_data,
    input  logic [1:0] req1_amt,
    output logic       req1_ready,
    output logic       res_valid,
    output logic [2:0] res_data,
    output logic       res_id,
    input  logic       res_ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] work_q, work_d;
    logic [1:0] cnt_q, cnt_d;
    logic       id_q, id_d;
    logic       last_q, last_d;   // index of the requester granted last

    logic       grant;            // requester that would be granted in IDLE
    logic       accept;
    logic [2:0] sel_data;
    logic [1:0] sel_amt;
    logic       shift_en;
    logic [2:0] shift_out;

    // Grant selection. With both valid, round robin picks the requester that
    // did not win last; last_q resets to 1 so requester 0 wins first.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = RR_EN ? ~last_q : 1'b0;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign accept     = (state_q == IDLE) && (grant ? req1_valid : req0_valid);
    assign req0_ready = accept & ~grant;
    assign req1_ready = accept & grant;
    assign sel_data   = grant ? req1_data : req0_data;
    assign sel_amt    = grant ? req1_amt  : req0_amt;

    assign shift_en = (state_q == SHIFT);

    shift1 u_shift1 (
        .s   (shift_en),
        .inp (work_q),
        .out (shift_out)
    );

    // Next-state logic.
    // NOTE: every signal gets a default first, so no path through the case
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    work_d  = sel_data;
                    cnt_d   = sel_amt;
                    id_d    = grant;
                    state_d = (sel_amt == 2'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                work_d = shift_out;
                cnt_d  = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Grant pointer only moves once the result has been handed off.
                if (res_ready) begin
                    state_d = IDLE;
                    last_d  = id_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update
    // together from values sampled before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= 3'b000;
            cnt_q   <= 2'd0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    // Result outputs are forced to zero outside DONE so intermediate shift
    // values never appear on the result bus.
    assign res_valid = (state_q == DONE);
    assign res_data  = res_valid ? work_q : 3'b000;
    assign res_id    = res_valid & id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_sequencer
//
// Directed bench for shift_sequencer. Two instances share all inputs: u_rr
// (round robin) and u_fp (fixed priority). Inputs change 1 time unit after
// the rising edge and outputs are sampled there, away from the active edge.
// -----------------------------------------------------------------------------
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       r0v, r1v, res_ready;
    logic [2:0] r0d, r1d;
    logic [1:0] r0a, r1a;

    logic       rr_r0rdy, rr_r1rdy, rr_valid, rr_id, rr_busy;
    logic [2:0] rr_data;
    logic       fp_r0rdy, fp_r1rdy, fp_valid, fp_id, fp_busy;
    logic [2:0] fp_data;

    int n_cmp = 0;
    int n_err = 0;

    logic rr_ids[$];
    logic fp_ids[$];
    logic exp_rr[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    shift_sequencer #(.RR_EN(1'b1)) u_rr (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (r0v),
        .req0_data  (r0d),
        .req0_amt   (r0a),
        .req0_ready (rr_r0rdy),
        .req1_valid (r1v),
        .req1_data  (r1d),
        .req1_amt   (r1a),
        .req1_ready (rr_r1rdy),
        .res_valid  (rr_valid),
        .res_data   (rr_data),
        .res_id     (rr_id),
        .res_ready  (res_ready),
        .busy       (rr_busy)
    );

    shift_sequencer #(.RR_EN(1'b0)) u_fp (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (r0v),
        .req0_data  (r0d),
        .req0_amt   (r0a),
        .req0_ready (fp_r0rdy),
        .req1_valid (r1v),
        .req1_data  (r1d),
        .req1_amt   (r1a),
        .req1_ready (fp_r1rdy),
        .res_valid  (fp_valid),
        .res_data   (fp_data),
        .res_id     (fp_id),
        .res_ready  (res_ready),
        .busy       (fp_busy)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        r0v = 1'b0; r0d = 3'b000; r0a = 2'd0;
        r1v = 1'b0; r1d = 3'b000; r1a = 2'd0;
        res_ready = 1'b1;
        #2;

        // Reset state
        check("rst_valid", 8'(rr_valid), 8'h0);
        check("rst_data",  8'(rr_data),  8'h0);
        check("rst_id",    8'(rr_id),    8'h0);
        check("rst_busy",  8'(rr_busy),  8'h0);
        check("rst_fp_busy", 8'(fp_busy), 8'h0);

        tick();
        rst_n = 1'b1;

        // req0: 3'b011 << 2 = 3'b100, result in the cycle after E0+2
        r0v = 1'b1; r0d = 3'b011; r0a = 2'd2;
        #1;
        check("j1_ready0", 8'(rr_r0rdy), 8'h1);
        check("j1_ready1", 8'(rr_r1rdy), 8'h0);
        tick();                                   // acceptance edge E0
        r0v = 1'b0; r0d = 3'b111; r0a = 2'd3;     // must not disturb the job
        check("j1_busy",   8'(rr_busy),  8'h1);
        check("j1_valid0", 8'(rr_valid), 8'h0);
        check("j1_rdy0_shift", 8'(rr_r0rdy), 8'h0);
        tick();
        check("j1_valid1", 8'(rr_valid), 8'h0);
        tick();
        check("j1_valid",  8'(rr_valid), 8'h1);
        check("j1_data",   8'(rr_data),  8'h4);
        check("j1_id",     8'(rr_id),    8'h0);
        tick();                                   // handoff
        check("j1_idle_valid", 8'(rr_valid), 8'h0);
        check("j1_idle_busy",  8'(rr_busy),  8'h0);

        // req1: amt 0 gives the operand back one cycle later
        r1v = 1'b1; r1d = 3'b101; r1a = 2'd0;
        #1;
        check("j2_ready1", 8'(rr_r1rdy), 8'h1);
        check("j2_ready0", 8'(rr_r0rdy), 8'h0);
        tick();
        r1v = 1'b0;
        check("j2_valid", 8'(rr_valid), 8'h1);
        check("j2_data",  8'(rr_data),  8'h5);
        check("j2_id",    8'(rr_id),    8'h1);
        tick();
        check("j2_idle_valid", 8'(rr_valid), 8'h0);

        // req1: 3'b111 << 3 = 3'b000, result after four cycles
        r1v = 1'b1; r1d = 3'b111; r1a = 2'd3;
        tick();
        r1v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("j3_wait_valid", 8'(rr_valid), 8'h0);
            tick();
        end
        check("j3_valid", 8'(rr_valid), 8'h1);
        check("j3_data",  8'(rr_data),  8'h0);
        check("j3_id",    8'(rr_id),    8'h1);

        // Consumer stall in DONE for five cycles with both requesters waiting
        res_ready = 1'b0;
        r0v = 1'b1; r1v = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid",  8'(rr_valid), 8'h1);
            check("stall_data",   8'(rr_data),  8'h0);
            check("stall_id",     8'(rr_id),    8'h1);
            check("stall_ready0", 8'(rr_r0rdy), 8'h0);
            check("stall_ready1", 8'(rr_r1rdy), 8'h0);
            check("stall_busy",   8'(rr_busy),  8'h1);
        end
        res_ready = 1'b1;
        tick();
        check("stall_end_valid", 8'(rr_valid), 8'h0);
        check("stall_end_busy",  8'(rr_busy),  8'h0);
        check("rr_after_id1_ready0", 8'(rr_r0rdy), 8'h1);
        check("rr_after_id1_ready1", 8'(rr_r1rdy), 8'h0);
        r0v = 1'b0; r1v = 1'b0;
        tick();
        check("no_accept_busy", 8'(rr_busy), 8'h0);

        // Reset during SHIFT of an amt 3 job
        r0v = 1'b1; r0d = 3'b111; r0a = 2'd3;
        tick();
        r0v = 1'b0;
        tick();
        check("abort_busy_pre", 8'(rr_busy), 8'h1);
        rst_n = 1'b0;
        #1;
        check("abort_busy",   8'(rr_busy),  8'h0);
        check("abort_valid",  8'(rr_valid), 8'h0);
        check("abort_data",   8'(rr_data),  8'h0);
        check("abort_id",     8'(rr_id),    8'h0);
        check("abort_ready0", 8'(rr_r0rdy), 8'h0);
        check("abort_ready1", 8'(rr_r1rdy), 8'h0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_abort_valid", 8'(rr_valid), 8'h0);
            check("post_abort_busy",  8'(rr_busy),  8'h0);
        end

        // Both requesters held valid: round robin alternates, fixed stays on 0
        r0v = 1'b1; r0d = 3'b001; r0a = 2'd0;
        r1v = 1'b1; r1d = 3'b010; r1a = 2'd0;
        #1;
        check("arb_rr_first0", 8'(rr_r0rdy), 8'h1);
        check("arb_rr_first1", 8'(rr_r1rdy), 8'h0);
        check("arb_fp_first0", 8'(fp_r0rdy), 8'h1);
        check("arb_fp_first1", 8'(fp_r1rdy), 8'h0);
        for (int c = 0; c < 40 && (rr_ids.size() < 4 || fp_ids.size() < 4); c++) begin
            tick();
            if (rr_valid && rr_ids.size() < 4) begin
                rr_ids.push_back(rr_id);
                check("arb_rr_data", 8'(rr_data), rr_id ? 8'h2 : 8'h1);
            end
            if (fp_valid && fp_ids.size() < 4) begin
                fp_ids.push_back(fp_id);
                check("arb_fp_data", 8'(fp_data), fp_id ? 8'h2 : 8'h1);
            end
        end
        r0v = 1'b0; r1v = 1'b0;
        check("arb_rr_count", 8'(rr_ids.size()), 8'h4);
        check("arb_fp_count", 8'(fp_ids.size()), 8'h4);
        for (int i = 0; i < 4; i++) begin
            if (i < rr_ids.size()) check("arb_rr_id", 8'(rr_ids[i]), 8'(exp_rr[i]));
            if (i < fp_ids.size()) check("arb_fp_id", 8'(fp_ids[i]), 8'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
